// File: rtl/core_config_pkg.sv
// Shared core configuration: widths, the decoded-operation enum and decode payload types.
package core_config_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [5:0] {
    i_NOP,
    i_LUI, i_AUIPC, i_JAL, i_JALR,
    i_BEQ, i_BNE, i_BLT, i_BGE, i_BLTU, i_BGEU,
    i_LB, i_LH, i_LW, i_LBU, i_LHU,
    i_SB, i_SH, i_SW,
    i_ADDI, i_SLTI, i_SLTIU, i_XORI, i_ORI, i_ANDI, i_SLLI, i_SRLI, i_SRAI,
    i_ADD, i_SUB, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_SRA, i_OR, i_AND,
    i_FENCE, i_ECALL, i_EBREAK, i_MRET,
    i_CSRRW, i_CSRRS, i_CSRRC, i_CSRRWI, i_CSRRSI, i_CSRRCI,
    i_MUL, i_MULH, i_MULHSU, i_MULHU, i_DIV, i_DIVU, i_REM, i_REMU
  } opcodes;

  // Instruction format class produced by the first decode stage.
  typedef enum logic [3:0] {
    F_ILL, F_R, F_OPIMM, F_LOAD, F_JALR, F_S, F_B,
    F_LUI, F_AUIPC, F_J, F_FENCE, F_SYS
  } fmt_e;

  typedef struct packed {
    opcodes                  op;
    logic [REG_ADDR_W-1:0]   rs1;
    logic [REG_ADDR_W-1:0]   rs2;
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN-1:0]         imm;
    logic                    use_rs1;
    logic                    use_rs2;
    logic                    use_rd;
    logic                    illegal;
  } dec_t;

endpackage

// File: rtl/rv_decode_pipe.sv
// RV32I(+M, +Zicsr) decode stage with valid/ready handshake, flush and 1- or 2-deep pipeline.
module rv_decode_pipe
  import core_config_pkg::*;
#(
  parameter int unsigned STAGES   = 2,
  parameter bit          EN_M     = 1'b1,
  parameter bit          EN_ZICSR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output opcodes                out_opcode,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_use_rs1,
  output logic                  out_use_rs2,
  output logic                  out_use_rd,
  output logic                  out_illegal
);

  // Major-opcode classification; anything not ending in 2'b11 is compressed and illegal.
  function automatic fmt_e classify(input logic [6:0] op7);
    fmt_e f;
    f = F_ILL;
    if (op7[1:0] == 2'b11) begin
      case (op7[6:2])
        5'b01100: f = F_R;
        5'b00100: f = F_OPIMM;
        5'b00000: f = F_LOAD;
        5'b11001: f = F_JALR;
        5'b01000: f = F_S;
        5'b11000: f = F_B;
        5'b01101: f = F_LUI;
        5'b00101: f = F_AUIPC;
        5'b11011: f = F_J;
        5'b00011: f = F_FENCE;
        5'b11100: f = F_SYS;
        default:  f = F_ILL;
      endcase
    end
    return f;
  endfunction

  function automatic dec_t decode(input logic [INSTR_W-1:0] ins, input fmt_e cls);
    dec_t        d;
    logic        ill;
    logic        wr;
    logic        csr_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [XLEN-1:0] imm_i;
    f3      = ins[14:12];
    f7      = ins[31:25];
    imm_i   = {{20{ins[31]}}, ins[31:20]};
    d       = '0;
    ill     = 1'b0;
    wr      = 1'b0;
    csr_imm = 1'b0;
    case (cls)
      F_R: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        wr        = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'd0: d.op = i_ADD;
              3'd1: d.op = i_SLL;
              3'd2: d.op = i_SLT;
              3'd3: d.op = i_SLTU;
              3'd4: d.op = i_XOR;
              3'd5: d.op = i_SRL;
              3'd6: d.op = i_OR;
              3'd7: d.op = i_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'd0)      d.op = i_SUB;
            else if (f3 == 3'd5) d.op = i_SRA;
            else                 ill  = 1'b1;
          end
          7'b0000001: begin
            if (!EN_M) ill = 1'b1;
            case (f3)
              3'd0: d.op = i_MUL;
              3'd1: d.op = i_MULH;
              3'd2: d.op = i_MULHSU;
              3'd3: d.op = i_MULHU;
              3'd4: d.op = i_DIV;
              3'd5: d.op = i_DIVU;
              3'd6: d.op = i_REM;
              3'd7: d.op = i_REMU;
            endcase
          end
          default: ill = 1'b1;
        endcase
      end
      F_OPIMM: begin
        d.use_rs1 = 1'b1;
        wr        = 1'b1;
        d.imm     = imm_i;
        case (f3)
          3'd0: d.op = i_ADDI;
          3'd2: d.op = i_SLTI;
          3'd3: d.op = i_SLTIU;
          3'd4: d.op = i_XORI;
          3'd6: d.op = i_ORI;
          3'd7: d.op = i_ANDI;
          3'd1: begin
            if (f7 == 7'b0000000) d.op = i_SLLI;
            else                  ill  = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      d.op = i_SRLI;
            else if (f7 == 7'b0100000) d.op = i_SRAI;
            else                       ill  = 1'b1;
          end
        endcase
      end
      F_LOAD: begin
        d.use_rs1 = 1'b1;
        wr        = 1'b1;
        d.imm     = imm_i;
        case (f3)
          3'd0:    d.op = i_LB;
          3'd1:    d.op = i_LH;
          3'd2:    d.op = i_LW;
          3'd4:    d.op = i_LBU;
          3'd5:    d.op = i_LHU;
          default: ill  = 1'b1;
        endcase
      end
      F_JALR: begin
        d.use_rs1 = 1'b1;
        wr        = 1'b1;
        d.imm     = imm_i;
        d.op      = i_JALR;
        if (f3 != 3'd0) ill = 1'b1;
      end
      F_S: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.imm     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        case (f3)
          3'd0:    d.op = i_SB;
          3'd1:    d.op = i_SH;
          3'd2:    d.op = i_SW;
          default: ill  = 1'b1;
        endcase
      end
      F_B: begin
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.imm     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        case (f3)
          3'd0:    d.op = i_BEQ;
          3'd1:    d.op = i_BNE;
          3'd4:    d.op = i_BLT;
          3'd5:    d.op = i_BGE;
          3'd6:    d.op = i_BLTU;
          3'd7:    d.op = i_BGEU;
          default: ill  = 1'b1;
        endcase
      end
      F_LUI, F_AUIPC: begin
        wr    = 1'b1;
        d.imm = {ins[31:12], 12'b0};
        d.op  = (cls == F_LUI) ? i_LUI : i_AUIPC;
      end
      F_J: begin
        wr    = 1'b1;
        d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d.op  = i_JAL;
      end
      F_FENCE: begin
        d.op = i_FENCE;
        if (f3 != 3'd0) ill = 1'b1;
      end
      F_SYS: begin
        case (f3)
          3'd0: begin
            if (ins == 32'h0000_0073)      d.op = i_ECALL;
            else if (ins == 32'h0010_0073) d.op = i_EBREAK;
            else if (ins == 32'h3020_0073) d.op = i_MRET;
            else                           ill  = 1'b1;
          end
          3'd1, 3'd2, 3'd3: begin
            d.use_rs1 = 1'b1;
            wr        = 1'b1;
            d.imm     = imm_i;
            d.op      = (f3 == 3'd1) ? i_CSRRW : (f3 == 3'd2) ? i_CSRRS : i_CSRRC;
            if (!EN_ZICSR) ill = 1'b1;
          end
          3'd5, 3'd6, 3'd7: begin
            csr_imm = 1'b1;
            wr      = 1'b1;
            d.imm   = imm_i;
            d.op    = (f3 == 3'd5) ? i_CSRRWI : (f3 == 3'd6) ? i_CSRRSI : i_CSRRCI;
            if (!EN_ZICSR) ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    // CSR immediate forms carry their zimm in the rs1 slot without reading a register.
    d.rs1    = (d.use_rs1 || csr_imm) ? ins[19:15] : '0;
    d.rs2    = d.use_rs2 ? ins[24:20] : '0;
    d.rd     = wr ? ins[11:7] : '0;
    d.use_rd = wr && (ins[11:7] != 5'd0);
    if (ill) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic                v0;
  logic [INSTR_W-1:0]  instr0;
  logic [XLEN-1:0]     pc0;
  logic                adv0;
  logic                dec_v;
  logic [INSTR_W-1:0]  dec_instr;
  fmt_e                dec_cls;
  logic [XLEN-1:0]     dec_pc;
  dec_t                dec_c;

  assign in_ready = !v0 || adv0;

  // Stage 0: capture instruction and PC; flush wins over any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0     <= 1'b0;
      instr0 <= '0;
      pc0    <= '0;
    end else if (flush) begin
      v0 <= 1'b0;
    end else if (in_ready) begin
      v0 <= in_valid;
      if (in_valid) begin
        instr0 <= in_instr;
        pc0    <= in_pc;
      end
    end
  end

  if (STAGES == 2) begin : g_two
    logic               v1;
    logic [INSTR_W-1:0] instr1;
    fmt_e               cls1;
    logic [XLEN-1:0]    pc1;

    assign adv0 = v0 && (!v1 || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1     <= 1'b0;
        instr1 <= '0;
        cls1   <= F_ILL;
        pc1    <= '0;
      end else if (flush) begin
        v1 <= 1'b0;
      end else if (!v1 || out_ready) begin
        v1 <= v0;
        if (v0) begin
          instr1 <= instr0;
          cls1   <= classify(instr0[6:0]);
          pc1    <= pc0;
        end
      end
    end

    assign dec_v     = v1;
    assign dec_instr = instr1;
    assign dec_cls   = cls1;
    assign dec_pc    = pc1;
  end else if (STAGES == 1) begin : g_one
    assign adv0      = v0 && out_ready;
    assign dec_v     = v0;
    assign dec_instr = instr0;
    assign dec_cls   = classify(instr0[6:0]);
    assign dec_pc    = pc0;
  end else begin : g_bad
    $error("rv_decode_pipe: STAGES must be 1 or 2");
  end

  always_comb begin
    dec_c = decode(dec_instr, dec_cls);
  end

  // Output bundle is forced to its idle value whenever no instruction is presented.
  always_comb begin
    out_valid   = dec_v;
    out_opcode  = i_NOP;
    out_rs1     = '0;
    out_rs2     = '0;
    out_rd      = '0;
    out_imm     = '0;
    out_pc      = '0;
    out_use_rs1 = 1'b0;
    out_use_rs2 = 1'b0;
    out_use_rd  = 1'b0;
    out_illegal = 1'b0;
    if (dec_v) begin
      out_opcode  = dec_c.op;
      out_rs1     = dec_c.rs1;
      out_rs2     = dec_c.rs2;
      out_rd      = dec_c.rd;
      out_imm     = dec_c.imm;
      out_pc      = dec_pc;
      out_use_rs1 = dec_c.use_rs1;
      out_use_rs2 = dec_c.use_rs2;
      out_use_rd  = dec_c.use_rd;
      out_illegal = dec_c.illegal;
    end
  end

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Directed bench: a 2-stage full-featured decoder and a 1-stage decoder without M/Zicsr share one input stream.
module tb_rv_decode_pipe;
  import core_config_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, out_use_rs1, out_use_rs2, out_use_rd, out_illegal;
  opcodes      out_opcode;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;

  logic        b_in_ready, b_out_valid, b_use_rs1, b_use_rs2, b_use_rd, b_illegal;
  opcodes      b_opcode;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [31:0] b_imm, b_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_decode_pipe #(.STAGES(2), .EN_M(1'b1), .EN_ZICSR(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2), .out_use_rd(out_use_rd),
    .out_illegal(out_illegal)
  );

  rv_decode_pipe #(.STAGES(1), .EN_M(1'b0), .EN_ZICSR(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_opcode(b_opcode),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
    .out_imm(b_imm), .out_pc(b_pc),
    .out_use_rs1(b_use_rs1), .out_use_rs2(b_use_rs2), .out_use_rd(b_use_rd),
    .out_illegal(b_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  logic [31:0] tw   [8];
  opcodes      top  [8];
  logic        till [8];
  logic        tbil [8];
  logic [31:0] timm [8];
  logic        turd [8];

  initial begin
    int sent;
    int rcvd;
    logic acc;

    tw[0] = 32'h0000_0000; top[0] = i_NOP;   till[0] = 1; tbil[0] = 1; timm[0] = 32'h0;   turd[0] = 0;
    tw[1] = 32'h0000_4501; top[1] = i_NOP;   till[1] = 1; tbil[1] = 1; timm[1] = 32'h0;   turd[1] = 0;
    tw[2] = 32'h0000_007F; top[2] = i_NOP;   till[2] = 1; tbil[2] = 1; timm[2] = 32'h0;   turd[2] = 0;
    tw[3] = 32'h4010_1093; top[3] = i_NOP;   till[3] = 1; tbil[3] = 1; timm[3] = 32'h0;   turd[3] = 0;
    tw[4] = 32'h4010_5093; top[4] = i_SRAI;  till[4] = 0; tbil[4] = 0; timm[4] = 32'h401; turd[4] = 1;
    tw[5] = 32'h3001_10F3; top[5] = i_CSRRW; till[5] = 0; tbil[5] = 1; timm[5] = 32'h300; turd[5] = 1;
    tw[6] = 32'h0000_0073; top[6] = i_ECALL; till[6] = 0; tbil[6] = 0; timm[6] = 32'h0;   turd[6] = 0;
    tw[7] = 32'h0080_006F; top[7] = i_JAL;   till[7] = 0; tbil[7] = 0; timm[7] = 32'h8;   turd[7] = 0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_opcode", 32'(out_opcode), 32'(i_NOP));
    check("rst_imm", out_imm, 32'd0);
    check("rst_illegal", 32'(out_illegal), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single ADDI through the 2-stage pipe; 1-stage decoder shows it one cycle earlier.
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    check("addi_lat_valid", 32'(out_valid), 32'd0);
    check("b_addi_op", 32'(b_opcode), 32'(i_ADDI));
    check("b_addi_valid", 32'(b_out_valid), 32'd1);
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_op", 32'(out_opcode), 32'(i_ADDI));
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_rs1", 32'(out_rs1), 32'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_use_rs1", 32'(out_use_rs1), 32'd1);
    check("addi_use_rs2", 32'(out_use_rs2), 32'd0);
    check("addi_use_rd", 32'(out_use_rd), 32'd1);
    check("addi_pc", out_pc, 32'h100);
    step();
    check("addi_drained", 32'(out_valid), 32'd0);

    // SUB, MUL, BEQ back to back.
    in_valid = 1'b1; in_instr = 32'h4020_81B3; in_pc = 32'h200;
    step();
    in_instr = 32'h0273_02B3; in_pc = 32'h204;
    step();
    check("sub_op", 32'(out_opcode), 32'(i_SUB));
    check("sub_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
    check("sub_use_rs2", 32'(out_use_rs2), 32'd1);
    check("b_mul_valid", 32'(b_out_valid), 32'd1);
    check("b_mul_illegal", 32'(b_illegal), 32'd1);
    check("b_mul_op", 32'(b_opcode), 32'(i_NOP));
    check("b_mul_use", {29'd0, b_use_rs1, b_use_rs2, b_use_rd}, 32'd0);
    check("b_mul_regs", {17'd0, b_rd, b_rs1, b_rs2}, 32'd0);
    check("b_mul_pc", b_pc, 32'h204);
    in_instr = 32'hFE00_0EE3; in_pc = 32'h208;
    step();
    in_valid = 1'b0;
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_op", 32'(out_opcode), 32'(i_MUL));
    check("mul_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd5, 5'd6, 5'd7});
    step();
    check("beq_valid", 32'(out_valid), 32'd1);
    check("beq_op", 32'(out_opcode), 32'(i_BEQ));
    check("beq_rs", {22'd0, out_rs1, out_rs2}, 32'd0);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_use_rd", 32'(out_use_rd), 32'd0);
    check("beq_pc", out_pc, 32'h208);
    step();
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Illegal and boundary encodings streamed back to back.
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_instr = (k < 8) ? tw[k] : 32'h0;
      in_pc    = 32'h300 + 32'(4 * k);
      step();
      if (k < 8) begin
        check($sformatf("b_tab%0d_valid", k), 32'(b_out_valid), 32'd1);
        check($sformatf("b_tab%0d_illegal", k), 32'(b_illegal), 32'(tbil[k]));
      end
      if (k >= 1) begin
        check($sformatf("tab%0d_valid", k - 1), 32'(out_valid), 32'd1);
        check($sformatf("tab%0d_op", k - 1), 32'(out_opcode), 32'(top[k - 1]));
        check($sformatf("tab%0d_illegal", k - 1), 32'(out_illegal), 32'(till[k - 1]));
        check($sformatf("tab%0d_imm", k - 1), out_imm, timm[k - 1]);
        check($sformatf("tab%0d_use_rd", k - 1), 32'(out_use_rd), 32'(turd[k - 1]));
        check($sformatf("tab%0d_pc", k - 1), out_pc, 32'h300 + 32'(4 * (k - 1)));
      end
    end
    in_valid = 1'b0;
    step();

    // Backpressure: continuous stream, out_ready low for 8 cycles then released.
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      in_valid  = (sent < 8);
      in_instr  = addi(10 + sent);
      in_pc     = 32'h1000 + 32'(4 * sent);
      out_ready = (cyc >= 8);
      #1;
      if (cyc >= 2 && cyc <= 7) begin
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_sent", 32'(sent), 32'd2);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_imm", out_imm, 32'd10);
        check("bp_hold_pc", out_pc, 32'h1000);
        check("bp_hold_op", 32'(out_opcode), 32'(i_ADDI));
      end
      if (cyc == 8) check("bp_release_ready", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        check("bp_order_imm", out_imm, 32'(10 + rcvd));
        check("bp_order_pc", out_pc, 32'h1000 + 32'(4 * rcvd));
        rcvd++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("bp_rcvd", 32'(rcvd), 32'd8);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush with a full pipe and a new instruction presented in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = addi(1); in_pc = 32'h500;
    step();
    in_instr = addi(2); in_pc = 32'h504;
    step();
    #1;
    check("fl_full_in_ready", 32'(in_ready), 32'd0);
    check("fl_full_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_instr = addi(3); in_pc = 32'h508;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_b_valid", 32'(b_out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_dropped", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset pulse with the pipe full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h4020_81B3; in_pc = 32'h600;
    step();
    in_pc = 32'h604;
    step();
    check("rp_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rp_out_valid", 32'(out_valid), 32'd0);
    check("rp_in_ready", 32'(in_ready), 32'd1);
    check("rp_opcode", 32'(out_opcode), 32'(i_NOP));
    check("rp_regs", {17'd0, out_rd, out_rs1, out_rs2}, 32'd0);
    check("rp_pc", out_pc, 32'd0);
    check("rp_use", {29'd0, out_use_rs1, out_use_rs2, out_use_rd}, 32'd0);
    check("rp_b_valid", 32'(b_out_valid), 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    check("rp_stays_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
